// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//  Shared definitions for the iterative multiply/divide unit: the ALU_OP_*
//  codes it services, the state encoding of its FSM, and small op-decode
//  helpers. The unit has no private op codes; it only recognises these four.
package muldiv_pkg;

   localparam logic [4:0] ALU_OP_MULT  = 5'h18;
   localparam logic [4:0] ALU_OP_MULTU = 5'h19;
   localparam logic [4:0] ALU_OP_DIV   = 5'h1A;
   localparam logic [4:0] ALU_OP_DIVU  = 5'h1B;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_PREP = 2'd1,
      MD_CALC = 2'd2,
      MD_FIX  = 2'd3
   } md_state_e;

   function automatic logic is_muldiv_op(input logic [4:0] op);
      return (op == ALU_OP_MULT) || (op == ALU_OP_MULTU) ||
             (op == ALU_OP_DIV)  || (op == ALU_OP_DIVU);
   endfunction

   function automatic logic is_div_op(input logic [4:0] op);
      return (op == ALU_OP_DIV) || (op == ALU_OP_DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [4:0] op);
      return (op == ALU_OP_MULT) || (op == ALU_OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit
//  Iterative signed/unsigned multiply and divide beside the ALU in EX. Owns
//  the architectural HI/LO registers and services MTHI/MTLO writes.
//  Operations take WIDTH+3 cycles from start to the done pulse; the pipeline
//  stalls MFHI/MFLO while busy is high.
// Ports
//  clk, rst        clock (rising edge), asynchronous active-high reset
//  start, op, a, b launch an operation (accepted only while idle)
//  hi_we, lo_we    MTHI / MTLO write strobes with data on wdata (idle only)
//  busy            operation in flight (PREP through FIX)
//  done            one-cycle pulse in the cycle HI/LO show a new result
//  hi, lo          HI (product upper / remainder), LO (product lower / quotient)
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   md_state_e        state_q, state_d;
   logic [4:0]       op_q, op_d;
   logic [WIDTH-1:0] hi_w_q, hi_w_d;      // accumulator upper / partial remainder
   logic [WIDTH-1:0] lo_w_q, lo_w_d;      // accumulator lower / multiplier / quotient
   logic [WIDTH-1:0] opnd_q, opnd_d;      // multiplicand / divisor magnitude
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             neg_q, neg_d;        // product / quotient must be negated
   logic             rem_neg_q, rem_neg_d;// remainder takes the dividend's sign
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quot;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d   = state_q;
      op_d      = op_q;
      hi_w_d    = hi_w_q;
      lo_w_d    = lo_w_q;
      opnd_d    = opnd_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;

      sum    = {1'b0, hi_w_q} + {1'b0, opnd_q};
      rem_sh = {hi_w_q, lo_w_q[WIDTH-1]};
      diff   = rem_sh - {1'b0, opnd_q};
      prod   = {hi_w_q, lo_w_q};
      quot   = lo_w_q;

      case (state_q)
         MD_IDLE: begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
            if (start && is_muldiv_op(op)) begin
               op_d    = op;
               lo_w_d  = a;
               opnd_d  = b;
               state_d = MD_PREP;
            end
         end

         MD_PREP: begin
            if (is_signed_op(op_q)) begin
               neg_d     = lo_w_q[WIDTH-1] ^ opnd_q[WIDTH-1];
               rem_neg_d = lo_w_q[WIDTH-1];
               lo_w_d    = lo_w_q[WIDTH-1] ? -lo_w_q : lo_w_q;
               opnd_d    = opnd_q[WIDTH-1] ? -opnd_q : opnd_q;
            end else begin
               neg_d     = 1'b0;
               rem_neg_d = 1'b0;
            end
            hi_w_d  = '0;
            cnt_d   = CW'(WIDTH - 1);
            state_d = MD_CALC;
         end

         MD_CALC: begin
            if (is_div_op(op_q)) begin
               // Restoring step: shift in the next dividend bit; keep the
               // subtraction only if it did not borrow.
               if (!diff[WIDTH]) begin
                  hi_w_d = diff[WIDTH-1:0];
                  lo_w_d = {lo_w_q[WIDTH-2:0], 1'b1};
               end else begin
                  hi_w_d = rem_sh[WIDTH-1:0];
                  lo_w_d = {lo_w_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               // Shift-add, LSB first: the multiplier drains out of lo_w as
               // the product fills in from the top, carry included.
               if (lo_w_q[0]) {hi_w_d, lo_w_d} = {sum, lo_w_q[WIDTH-1:1]};
               else           {hi_w_d, lo_w_d} = {1'b0, hi_w_q, lo_w_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) state_d = MD_FIX;
         end

         MD_FIX: begin
            if (is_div_op(op_q)) begin
               // A zero divisor leaves an all-ones quotient, which is
               // reported unsigned; the remainder sign rule then restores a.
               if (opnd_q == '0) quot = '1;
               else if (neg_q)   quot = -lo_w_q;
               lo_d = quot;
               hi_d = rem_neg_q ? -hi_w_q : hi_w_q;
            end else begin
               {hi_d, lo_d} = neg_q ? -prod : prod;
            end
            done_d  = 1'b1;
            state_d = MD_IDLE;
         end

         default: state_d = MD_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values computed above regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= MD_IDLE;
         op_q      <= '0;
         hi_w_q    <= '0;
         lo_w_q    <= '0;
         opnd_q    <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         hi_w_q    <= hi_w_d;
         lo_w_q    <= lo_w_d;
         opnd_q    <= opnd_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign busy = (state_q != MD_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
